// File: rtl/banked_ram.sv
// Bank-switched work RAM: fixed bank-0 window, switchable bank register,
// one-cycle registered read port and a clear engine that fills the array.
module banked_ram #(
   parameter int                    DATA_WIDTH       = 8,
   parameter int                    ADDR_WIDTH       = 12,
   parameter int                    BANK_COUNT       = 8,
   parameter int                    BANK_BITS        = $clog2(BANK_COUNT),
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE       = '0,
   parameter bit                    ZERO_MAPS_TO_ONE = 1'b1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Enable,
   input  logic                  i_Bus_Enable,
   input  logic                  i_ReadWrite,
   input  logic [ADDR_WIDTH-1:0] i_Address,
   input  logic                  i_Fixed_Region,
   input  logic [DATA_WIDTH-1:0] i_Bus,
   output logic [DATA_WIDTH-1:0] o_Bus,
   output logic                  o_Valid,
   input  logic                  i_Bank_Write,
   input  logic [BANK_BITS-1:0]  i_Bank,
   output logic [BANK_BITS-1:0]  o_Bank,
   input  logic                  i_Clear,
   output logic                  o_Busy
);

   localparam int                    DEPTH      = BANK_COUNT * (2 ** ADDR_WIDTH);
   localparam int                    IDX_WIDTH  = BANK_BITS + ADDR_WIDTH;
   localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(DEPTH - 1);
   localparam logic [BANK_BITS-1:0]  BANK_ONE   = BANK_BITS'(1);
   localparam logic [BANK_BITS-1:0]  BANK_RESET = ZERO_MAPS_TO_ONE ? BANK_ONE : '0;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                state;
   logic [IDX_WIDTH-1:0]  clear_idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [BANK_BITS-1:0]  bank_eff;
   logic [IDX_WIDTH-1:0]  bus_idx;
   logic                  access;
   logic                  do_write;
   logic                  do_read;

   assign o_Busy   = (state == S_CLEAR);
   assign bank_eff = i_Fixed_Region ? '0 : o_Bank;
   assign bus_idx  = {bank_eff, i_Address};
   // Reset and a running clear both swallow bus cycles.
   assign access   = i_Enable & i_Bus_Enable & ~o_Busy & ~i_Rst;
   assign do_write = access & i_ReadWrite;
   assign do_read  = access & ~i_ReadWrite;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= S_CLEAR;
         clear_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_Clear) begin
                  state     <= S_CLEAR;
                  clear_idx <= '0;
               end
            end
            S_CLEAR: begin
               if (clear_idx == LAST_IDX) state <= S_IDLE;
               clear_idx <= clear_idx + IDX_WIDTH'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Bank <= BANK_RESET;
      end else if (i_Bank_Write) begin
         o_Bank <= (ZERO_MAPS_TO_ONE && i_Bank == '0) ? BANK_ONE : i_Bank;
      end
   end

   // NOTE: the array has no reset term; the clear engine is its only initialiser.
   always_ff @(posedge i_Clk) begin
      if (o_Busy && !i_Rst) begin
         mem[clear_idx] <= FILL_VALUE;
      end else if (do_write) begin
         mem[bus_idx] <= i_Bus;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst || !do_read) begin
         o_Valid <= 1'b0;
         o_Bus   <= '0;
      end else begin
         o_Valid <= 1'b1;
         o_Bus   <= mem[bus_idx];
      end
   end

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: array/countdown model compared every cycle,
// plus directed vectors with literal expectations.
module tb_banked_ram;

   localparam int         DW    = 8;
   localparam int         AW    = 4;
   localparam int         BC    = 4;
   localparam int         BB    = 2;
   localparam int         DEPTH = 64;
   localparam logic [7:0] FILL  = 8'hFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0, ben = 1'b0, rw = 1'b0, fixed = 1'b0;
   logic          bwr = 1'b0, clr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [BB-1:0] bank_in = '0;
   logic [DW-1:0] rdata;
   logic          valid, busy;
   logic [BB-1:0] bank_out;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   banked_ram #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_COUNT(BC),
      .FILL_VALUE(FILL), .ZERO_MAPS_TO_ONE(1'b1)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Bus_Enable(ben),
      .i_ReadWrite(rw), .i_Address(addr), .i_Fixed_Region(fixed),
      .i_Bus(wdata), .o_Bus(rdata), .o_Valid(valid),
      .i_Bank_Write(bwr), .i_Bank(bank_in), .o_Bank(bank_out),
      .i_Clear(clr), .o_Busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: flat word array, busy countdown, plain bank number.
   logic [7:0] m_mem [DEPTH];
   int         m_busy_left = 0;
   int         m_bank = 1;
   logic       m_valid = 1'b0;
   logic [7:0] m_bus = '0;
   bit         checking = 1'b0;

   always @(posedge clk) begin
      int idx;
      m_valid = 1'b0;
      m_bus   = '0;
      if (rst) begin
         m_busy_left = DEPTH;
         m_bank      = 1;
         checking    = 1'b1;
      end else begin
         idx = fixed ? int'(addr) : m_bank * 16 + int'(addr);
         if (en && ben && m_busy_left == 0) begin
            if (rw) m_mem[idx] = wdata;
            else begin
               m_valid = 1'b1;
               m_bus   = m_mem[idx];
            end
         end
         if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = FILL;
            m_busy_left--;
         end else if (clr) begin
            m_busy_left = DEPTH;
         end
         if (bwr) m_bank = (bank_in == 0) ? 1 : int'(bank_in);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("busy", busy, (m_busy_left != 0));
         check("bank", bank_out, m_bank);
         check("valid", valid, m_valid);
         check("bus", rdata, m_bus);
      end
   end

   task automatic idle();
      en = 1'b0; ben = 1'b0; rw = 1'b0; fixed = 1'b0; bwr = 1'b0; clr = 1'b0;
   endtask

   task automatic wr(input int a, input bit fx, input logic [7:0] d);
      en = 1'b1; ben = 1'b1; rw = 1'b1; fixed = fx; addr = AW'(a); wdata = d;
      @(negedge clk);
      idle();
   endtask

   // Leaves the bus driven so consecutive calls issue back-to-back reads.
   task automatic rd(input int a, input bit fx, input logic [7:0] exp);
      en = 1'b1; ben = 1'b1; rw = 1'b0; fixed = fx; addr = AW'(a);
      @(negedge clk);
      check($sformatf("rd_valid@%0h", a), valid, 1);
      check($sformatf("rd_data@%0h", a), rdata, exp);
   endtask

   task automatic set_bank(input int b);
      idle();
      bwr = 1'b1; bank_in = BB'(b);
      @(negedge clk);
      bwr = 1'b0;
      check("set_bank", bank_out, (b == 0) ? 1 : b);
   endtask

   task automatic readback_all();
      for (int b = 1; b < BC; b++) begin
         set_bank(b);
         for (int a = 0; a < 16; a++) rd(a, 1'b0, FILL);
         idle();
      end
      for (int a = 0; a < 16; a++) rd(a, 1'b1, FILL);
      idle();
      @(negedge clk);
      check("idle_valid_low", valid, 0);
      check("idle_bus_zero", rdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      // Reset-clear
      idle();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_bank", bank_out, 1);
      check("reset_valid", valid, 0);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("reset_busy_cycles", n, 64);
      readback_all();

      // Bank isolation
      set_bank(2); wr(3, 1'b0, 8'hA5);
      set_bank(3); wr(3, 1'b0, 8'h5A);
      set_bank(2); rd(3, 1'b0, 8'hA5); idle();
      set_bank(3); rd(3, 1'b0, 8'h5A); idle();

      // Zero mapping and fixed window
      set_bank(0);
      check("zero_maps_to_one", bank_out, 1);
      wr(5, 1'b1, 8'h11);
      set_bank(3); rd(5, 1'b1, 8'h11); idle();
      set_bank(1); rd(5, 1'b0, FILL); idle();

      // Gating: disabled writes must not land
      en = 1'b0; ben = 1'b1; rw = 1'b1; addr = 4'h7; wdata = 8'h77;
      @(negedge clk);
      check("gated_en_bus_zero", rdata, 0);
      idle();
      en = 1'b1; ben = 1'b0; rw = 1'b1; addr = 4'h7; wdata = 8'h78;
      @(negedge clk);
      idle();
      rd(7, 1'b0, FILL); idle();

      // Same-edge bank write and read: old bank used
      wr(9, 1'b0, 8'h42);
      en = 1'b1; ben = 1'b1; rw = 1'b0; addr = 4'h9; bwr = 1'b1; bank_in = 2'd2;
      @(negedge clk);
      check("same_edge_data", rdata, 8'h42);
      check("same_edge_bank", bank_out, 2);
      idle();
      rd(9, 1'b0, FILL); idle();

      // Clear on request with dropped write, read and re-pulse during busy
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (n == 8) check("busy_read_no_valid", valid, 0);
         idle();
         if (n == 5) begin en = 1'b1; ben = 1'b1; rw = 1'b1; addr = 4'h3; wdata = 8'h33; end
         if (n == 7) begin en = 1'b1; ben = 1'b1; rw = 1'b0; addr = 4'h3; end
         if (n == 10) clr = 1'b1;
         @(negedge clk);
      end
      idle();
      check("clear_busy_cycles", n, 64);
      readback_all();

      // Reset at cycle 20 of a clear restarts the full sweep
      set_bank(3);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         n++;
         rst = (n == 20);
         @(negedge clk);
      end
      rst = 1'b0;
      check("reset_mid_clear_cycles", n, 20 + 64);
      check("reset_mid_clear_bank", bank_out, 1);
      readback_all();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
